// File: rtl/expmul_sched_pkg.sv
// Shared types and defaults for the expmul issue scheduler.
// Included by every expmul_sched file through import expmul_sched_pkg::*.
package expmul_sched_pkg;

  localparam int SCORE_W          = 16;
  localparam int MAX_SEQ_LENGTH   = 64;
  localparam int DEFAULT_SEQ_LEN  = MAX_SEQ_LENGTH;
  localparam int DEFAULT_NUM_ROWS = MAX_SEQ_LENGTH;

  // A counter over n values needs at least one bit, even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_ROW_W = cnt_width(DEFAULT_NUM_ROWS);

  typedef logic signed [SCORE_W-1:0] SCORE_T;

  localparam SCORE_T SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef struct packed {
    SCORE_T                   s;
    SCORE_T                   m;
    SCORE_T                   m_prev;
    logic                     first;
    logic                     last;
    logic [DEFAULT_ROW_W-1:0] row;
  } EXPMUL_ISSUE_T;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/expmul_sched_if.sv
// Score-in / issue-tuple-out handshake bundle for expmul_sched.
// slave is the scheduler side, master is the producer/consumer side.
interface expmul_sched_if
  import expmul_sched_pkg::*;
#(
  parameter int DATA_W = SCORE_W,
  parameter int ROW_W  = DEFAULT_ROW_W
) ();

  logic                     s_vld;
  logic                     s_rdy;
  logic signed [DATA_W-1:0] s_data;

  logic                     out_vld;
  logic                     out_rdy;
  logic signed [DATA_W-1:0] out_s;
  logic signed [DATA_W-1:0] out_m;
  logic signed [DATA_W-1:0] out_m_prev;
  logic                     out_first;
  logic                     out_last;
  logic [ROW_W-1:0]         out_row;

  modport slave (
    input  s_vld, s_data, out_rdy,
    output s_rdy, out_vld, out_s, out_m, out_m_prev, out_first, out_last, out_row
  );

  modport master (
    output s_vld, s_data, out_rdy,
    input  s_rdy, out_vld, out_s, out_m, out_m_prev, out_first, out_last, out_row
  );

endinterface

// File: rtl/expmul_sched_running_max.sv
// Running row maximum for expmul_sched: selects m_prev/m for the current key
// and holds the max register between keys of a row.
module running_max_unit
  import expmul_sched_pkg::*;
#(
  parameter int DATA_W = SCORE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     accept,
  input  logic                     first,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] s_data,
  output logic signed [DATA_W-1:0] mp,
  output logic signed [DATA_W-1:0] mn
);

  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] m_q;
  logic signed [DATA_W-1:0] m_d;

  // Ties keep the previous max; the register reloads MIN_VAL at row end.
  always_comb begin
    mp  = first ? MIN_VAL : m_q;
    mn  = (s_data > mp) ? s_data : mp;
    m_d = m_q;
    if (clear) begin
      m_d = MIN_VAL;
    end else if (accept) begin
      m_d = last ? MIN_VAL : mn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= MIN_VAL;
    end else begin
      m_q <= m_d;
    end
  end

endmodule

// File: rtl/expmul_sched.sv
// Issue-side scheduler feeding the expmul pair: one tuple per key, SEQ_LEN keys
// per row, NUM_ROWS rows per job. Define EXPMUL_SCHED_PERF_EN for stall/starve counters.
module expmul_sched
  import expmul_sched_pkg::*;
#(
  parameter int DATA_W   = SCORE_W,
  parameter int SEQ_LEN  = DEFAULT_SEQ_LEN,
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef EXPMUL_SCHED_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] starve_cnt,
`endif
  expmul_sched_if.slave bus
);

  localparam int KEY_W = cnt_width(SEQ_LEN);
  localparam int ROW_W = cnt_width(NUM_ROWS);
  localparam logic [KEY_W-1:0] KEY_LAST = KEY_W'(SEQ_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  sched_state_t             state_q, state_d;
  logic [KEY_W-1:0]         key_cnt_q, key_cnt_d;
  logic [ROW_W-1:0]         row_cnt_q, row_cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     out_vld_q, out_vld_d;
  logic signed [DATA_W-1:0] out_s_q, out_s_d;
  logic signed [DATA_W-1:0] out_m_q, out_m_d;
  logic signed [DATA_W-1:0] out_m_prev_q, out_m_prev_d;
  logic                     out_first_q, out_first_d;
  logic                     out_last_q, out_last_d;
  logic [ROW_W-1:0]         out_row_q, out_row_d;

  logic                     start_ok;
  logic                     s_rdy;
  logic                     accept;
  logic                     key_first;
  logic                     key_last;
  logic                     row_last;
  logic signed [DATA_W-1:0] mp;
  logic signed [DATA_W-1:0] mn;

  assign start_ok  = (state_q == ST_IDLE) && start;
  assign s_rdy     = (state_q == ST_RUN) && (!out_vld_q || bus.out_rdy);
  assign accept    = bus.s_vld && s_rdy;
  assign key_first = (key_cnt_q == '0);
  assign key_last  = (key_cnt_q == KEY_LAST);
  assign row_last  = (row_cnt_q == ROW_LAST);

  running_max_unit #(
    .DATA_W (DATA_W)
  ) u_max (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .accept (accept),
    .first  (key_first),
    .last   (key_last),
    .s_data (bus.s_data),
    .mp     (mp),
    .mn     (mn)
  );

  // Output register accepts a new tuple whenever it is empty or being drained.
  always_comb begin
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    row_cnt_d    = row_cnt_q;
    out_vld_d    = out_vld_q;
    out_s_d      = out_s_q;
    out_m_d      = out_m_q;
    out_m_prev_d = out_m_prev_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    out_row_d    = out_row_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          key_cnt_d = '0;
          row_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (key_last) begin
            key_cnt_d = '0;
            if (row_last) begin
              row_cnt_d = '0;
              state_d   = ST_DRAIN;
            end else begin
              row_cnt_d = row_cnt_q + ROW_W'(1);
            end
          end else begin
            key_cnt_d = key_cnt_q + KEY_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!out_vld_q || bus.out_rdy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      out_vld_d    = 1'b1;
      out_s_d      = bus.s_data;
      out_m_d      = mn;
      out_m_prev_d = mp;
      out_first_d  = key_first;
      out_last_d   = key_last;
      out_row_d    = row_cnt_q;
    end else if (bus.out_rdy) begin
      out_vld_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_cnt_q    <= '0;
      row_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_vld_q    <= 1'b0;
      out_s_q      <= '0;
      out_m_q      <= '0;
      out_m_prev_q <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_row_q    <= '0;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      row_cnt_q    <= row_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_vld_q    <= out_vld_d;
      out_s_q      <= out_s_d;
      out_m_q      <= out_m_d;
      out_m_prev_q <= out_m_prev_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_row_q    <= out_row_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.s_rdy      = s_rdy;
  assign bus.out_vld    = out_vld_q;
  assign bus.out_s      = out_s_q;
  assign bus.out_m      = out_m_q;
  assign bus.out_m_prev = out_m_prev_q;
  assign bus.out_first  = out_first_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_row    = out_row_q;

`ifdef EXPMUL_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] starve_cnt_q, starve_cnt_d;

  // Both counters restart with each job and stick at all-ones.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (start_ok) begin
      stall_cnt_d  = '0;
      starve_cnt_d = '0;
    end else begin
      if (out_vld_q && !bus.out_rdy && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if ((state_q == ST_RUN) && s_rdy && !bus.s_vld && (starve_cnt_q != '1)) begin
        starve_cnt_d = starve_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_expmul_sched.sv
// Directed bench for expmul_sched using three configurations:
// A = 4 keys x 1 row, B = 2 keys x 3 rows, C = 1 key x 2 rows.
`timescale 1ns/1ps
module tb_expmul_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef EXPMUL_SCHED_PERF_EN
  logic [31:0] stall_a, starve_a, stall_b, starve_b, stall_c, starve_c;
`endif

  expmul_sched_if #(.DATA_W(16), .ROW_W(1)) bus_a ();
  expmul_sched_if #(.DATA_W(16), .ROW_W(2)) bus_b ();
  expmul_sched_if #(.DATA_W(16), .ROW_W(1)) bus_c ();

  expmul_sched #(.DATA_W(16), .SEQ_LEN(4), .NUM_ROWS(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
`ifdef EXPMUL_SCHED_PERF_EN
    .stall_cnt(stall_a), .starve_cnt(starve_a),
`endif
    .bus(bus_a.slave)
  );

  expmul_sched #(.DATA_W(16), .SEQ_LEN(2), .NUM_ROWS(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
`ifdef EXPMUL_SCHED_PERF_EN
    .stall_cnt(stall_b), .starve_cnt(starve_b),
`endif
    .bus(bus_b.slave)
  );

  expmul_sched #(.DATA_W(16), .SEQ_LEN(1), .NUM_ROWS(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
`ifdef EXPMUL_SCHED_PERF_EN
    .stall_cnt(stall_c), .starve_cnt(starve_c),
`endif
    .bus(bus_c.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bus_a.s_vld = 1'b0; bus_a.s_data = '0; bus_a.out_rdy = 1'b1;
    bus_b.s_vld = 1'b0; bus_b.s_data = '0; bus_b.out_rdy = 1'b1;
    bus_c.s_vld = 1'b0; bus_c.s_data = '0; bus_c.out_rdy = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_a.u_max.m_q !== 16'h8000 || bus_a.out_m !== 16'h0 || bus_a.out_s !== 16'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_values: m_reg=%h out_m=%h out_s=%h, want 8000 0000 0000",
               dut_a.u_max.m_q, bus_a.out_m, bus_a.out_s);
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if ({busy_a, bus_a.s_rdy, bus_a.out_vld, done_a, done_b, done_c} !== 6'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_idle cyc%0d: busy=%b s_rdy=%b out_vld=%b done=%b%b%b, want all 0",
                 i, busy_a, bus_a.s_rdy, bus_a.out_vld, done_a, done_b, done_c);
      end
      step();
    end
  endtask

  task automatic test_running_max();
    logic [15:0] sc  [4] = '{16'd3, 16'hFFFB, 16'd7, 16'd7};
    logic [15:0] em  [4] = '{16'd3, 16'd3, 16'd7, 16'd7};
    logic [15:0] emp [4] = '{16'h8000, 16'd3, 16'd3, 16'd7};
    logic        ef  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        el  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_a.s_vld = 1'b1;
      bus_a.s_data = sc[k];
      #1;
      n_cmp++;
      if (bus_a.s_rdy !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL rmax_srdy%0d: s_rdy=%b, want 1", k, bus_a.s_rdy);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus_a.out_vld, bus_a.out_s, bus_a.out_m, bus_a.out_m_prev, bus_a.out_first,
           bus_a.out_last, bus_a.out_row, done_a} !==
          {1'b1, sc[k], em[k], emp[k], ef[k], el[k], 1'b0, 1'b0}) begin
        n_bad++;
        $display("[TB] FAIL rmax_tuple%0d: vld=%b s=%h m=%h mp=%h f=%b l=%b row=%h done=%b, want 1 %h %h %h %b %b 0 0",
                 k, bus_a.out_vld, bus_a.out_s, bus_a.out_m, bus_a.out_m_prev, bus_a.out_first,
                 bus_a.out_last, bus_a.out_row, done_a, sc[k], em[k], emp[k], ef[k], el[k]);
      end
    end
    bus_a.s_vld = 1'b0;
    step();
    n_cmp++;
    if (done_a !== 1'b1 || busy_a !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rmax_done: done=%b busy=%b, want 1 1", done_a, busy_a);
    end
    step();
    n_cmp++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL rmax_idle: done=%b busy=%b, want 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] sc  [4] = '{16'd10, 16'd20, 16'hFFFD, 16'd15};
    logic [15:0] em  [4] = '{16'd10, 16'd20, 16'd20, 16'd20};
    logic [15:0] emp [4] = '{16'h8000, 16'd10, 16'd20, 16'd20};
    do_reset();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_a.s_vld = 1'b1;
      bus_a.s_data = sc[k];
      if (k == 2) begin
        bus_a.out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #1;
          n_cmp++;
          if (bus_a.s_rdy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL bp_srdy cyc%0d: s_rdy=%b, want 0", c, bus_a.s_rdy);
          end
          @(posedge clk);
          #1;
          n_cmp++;
          if ({bus_a.out_vld, bus_a.out_s, bus_a.out_m, bus_a.out_m_prev, bus_a.out_first} !==
              {1'b1, 16'd20, 16'd20, 16'd10, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL bp_hold cyc%0d: vld=%b s=%h m=%h mp=%h f=%b, want 1 0014 0014 000a 0",
                     c, bus_a.out_vld, bus_a.out_s, bus_a.out_m, bus_a.out_m_prev, bus_a.out_first);
          end
        end
        bus_a.out_rdy = 1'b1;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus_a.out_vld, bus_a.out_s, bus_a.out_m, bus_a.out_m_prev, bus_a.out_last} !==
          {1'b1, sc[k], em[k], emp[k], (k == 3)}) begin
        n_bad++;
        $display("[TB] FAIL bp_tuple%0d: vld=%b s=%h m=%h mp=%h l=%b, want 1 %h %h %h %b",
                 k, bus_a.out_vld, bus_a.out_s, bus_a.out_m, bus_a.out_m_prev, bus_a.out_last,
                 sc[k], em[k], emp[k], (k == 3));
      end
    end
    bus_a.s_vld = 1'b0;
    step();
    n_cmp++;
    if (done_a !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL bp_done: done=%b, want 1", done_a);
    end
`ifdef EXPMUL_SCHED_PERF_EN
    n_cmp++;
    if (stall_a !== 32'd5 || starve_a !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL bp_perf: stall=%0d starve=%0d, want 5 0", stall_a, starve_a);
    end
`endif
    step();
  endtask

  task automatic test_row_wrap();
    logic [15:0] sc  [6] = '{16'd9, 16'd1, 16'hFFFE, 16'hFFFC, 16'd0, 16'd5};
    logic [15:0] em  [6] = '{16'd9, 16'd9, 16'hFFFE, 16'hFFFE, 16'd0, 16'd5};
    logic [15:0] emp [6] = '{16'h8000, 16'd9, 16'h8000, 16'hFFFE, 16'h8000, 16'd0};
    logic [1:0]  er  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    do_reset();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus_b.s_vld = 1'b1;
      bus_b.s_data = sc[k];
      step();
      n_cmp++;
      if ({bus_b.out_vld, bus_b.out_s, bus_b.out_m, bus_b.out_m_prev, bus_b.out_first,
           bus_b.out_last, bus_b.out_row} !==
          {1'b1, sc[k], em[k], emp[k], (k % 2 == 0), (k % 2 == 1), er[k]}) begin
        n_bad++;
        $display("[TB] FAIL wrap_tuple%0d: vld=%b s=%h m=%h mp=%h f=%b l=%b row=%0d, want 1 %h %h %h %b %b %0d",
                 k, bus_b.out_vld, bus_b.out_s, bus_b.out_m, bus_b.out_m_prev, bus_b.out_first,
                 bus_b.out_last, bus_b.out_row, sc[k], em[k], emp[k], (k % 2 == 0), (k % 2 == 1), er[k]);
      end
    end
    bus_b.s_vld = 1'b0;
    n_cmp++;
    if (busy_b !== 1'b1 || done_b !== 1'b0 || bus_b.s_rdy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL wrap_drain: busy=%b done=%b s_rdy=%b, want 1 0 0", busy_b, done_b, bus_b.s_rdy);
    end
    step();
    n_cmp++;
    if (done_b !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL wrap_done: done=%b, want 1", done_b);
    end
    step();
    n_cmp++;
    if (done_b !== 1'b0 || busy_b !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL wrap_idle: done=%b busy=%b, want 0 0", done_b, busy_b);
    end
  endtask

  task automatic test_control_edges();
    logic [15:0] sc  [4] = '{16'd11, 16'd12, 16'd13, 16'd6};
    logic [15:0] em  [4] = '{16'd11, 16'd12, 16'd13, 16'd6};
    logic [15:0] emp [4] = '{16'h8000, 16'd11, 16'h8000, 16'h8000};
    logic        ef  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  er  [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    do_reset();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus_b.s_vld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (busy_b !== 1'b0 || bus_b.out_vld !== 1'b0 || bus_b.s_rdy !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL ctl_abort: busy=%b out_vld=%b s_rdy=%b, want 0 0 0",
                   busy_b, bus_b.out_vld, bus_b.s_rdy);
        end
        for (int c = 0; c < 5; c++) begin
          n_cmp++;
          if (done_b !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ctl_nodone cyc%0d: done=%b, want 0", c, done_b);
          end
          step();
        end
        start_b = 1'b1;
        step();
        start_b = 1'b0;
      end
      start_b = (k == 1);
      bus_b.s_vld = 1'b1;
      bus_b.s_data = sc[k];
      step();
      n_cmp++;
      if ({bus_b.out_vld, bus_b.out_m, bus_b.out_m_prev, bus_b.out_first, bus_b.out_row, busy_b} !==
          {1'b1, em[k], emp[k], ef[k], er[k], 1'b1}) begin
        n_bad++;
        $display("[TB] FAIL ctl_tuple%0d: vld=%b m=%h mp=%h f=%b row=%0d busy=%b, want 1 %h %h %b %0d 1",
                 k, bus_b.out_vld, bus_b.out_m, bus_b.out_m_prev, bus_b.out_first, bus_b.out_row,
                 busy_b, em[k], emp[k], ef[k], er[k]);
      end
    end
    start_b = 1'b0;
    do_reset();
  endtask

  task automatic test_seq_len_one();
    do_reset();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    bus_c.s_vld = 1'b1;
    bus_c.s_data = 16'd4;
    step();
    bus_c.out_rdy = 1'b0;
    bus_c.s_data = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus_c.s_rdy !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL one_srdy cyc%0d: s_rdy=%b, want 0", c, bus_c.s_rdy);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus_c.out_vld, bus_c.out_s, bus_c.out_m, bus_c.out_m_prev, bus_c.out_first,
           bus_c.out_last, bus_c.out_row} !== {1'b1, 16'd4, 16'd4, 16'h8000, 1'b1, 1'b1, 1'b0}) begin
        n_bad++;
        $display("[TB] FAIL one_tuple0 cyc%0d: vld=%b s=%h m=%h mp=%h f=%b l=%b row=%0d, want 1 0004 0004 8000 1 1 0",
                 c, bus_c.out_vld, bus_c.out_s, bus_c.out_m, bus_c.out_m_prev, bus_c.out_first,
                 bus_c.out_last, bus_c.out_row);
      end
    end
    bus_c.out_rdy = 1'b1;
    step();
    bus_c.s_vld = 1'b0;
    n_cmp++;
    if ({bus_c.out_vld, bus_c.out_s, bus_c.out_m, bus_c.out_m_prev, bus_c.out_first,
         bus_c.out_last, bus_c.out_row} !== {1'b1, 16'hFFFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL one_tuple1: vld=%b s=%h m=%h mp=%h f=%b l=%b row=%0d, want 1 ffff ffff 8000 1 1 1",
               bus_c.out_vld, bus_c.out_s, bus_c.out_m, bus_c.out_m_prev, bus_c.out_first,
               bus_c.out_last, bus_c.out_row);
    end
    step();
    n_cmp++;
    if (done_c !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL one_done: done=%b, want 1", done_c);
    end
`ifdef EXPMUL_SCHED_PERF_EN
    n_cmp++;
    if (stall_c !== 32'd3) begin
      n_bad++;
      $display("[TB] FAIL one_stall: stall_cnt=%0d, want 3", stall_c);
    end
`endif
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] expmul_sched directed tests");
    test_reset();
    test_running_max();
    test_backpressure();
    test_row_wrap();
    test_control_edges();
    test_seq_len_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
